// File: rtl/usb_tx_wire_driver.sv
// rtl/usb_tx_wire_driver.sv - USB wire transmit sink: symbol FIFO replayed one entry per bit period
// Entries are {ctl, bits}; the line-drive outputs only ever change on a bit tick that pops.
module usb_tx_wire_driver #(
   parameter int FIFO_ADDR_W = 2,
   parameter int FS_DIV      = 4,
   parameter int LS_DIV      = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] TxBits,
   input  logic       TxCtl,
   input  logic       USBWireWEn,
   output logic       USBWireRdy,
   input  logic       fullSpeedRate,
   output logic [1:0] USBWireDataOut,
   output logic       USBWireCtrlOut,
   output logic       txActive,
   output logic       txUnderrun,
   output logic       txOverflow
);

   localparam int DEPTH = 1 << FIFO_ADDR_W;
   localparam int CNT_W = $clog2((LS_DIV > FS_DIV) ? LS_DIV : FS_DIV) + 1;
   localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(FS_DIV - 1);
   localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LS_DIV - 1);
   localparam logic [FIFO_ADDR_W:0] DEPTH_C = (FIFO_ADDR_W + 1)'(DEPTH);

   localparam logic [0:0] WIRE_IDLE   = 1'b0;
   localparam logic [0:0] WIRE_ACTIVE = 1'b1;

   logic [2:0]             mem_q [DEPTH];
   logic [2:0]             mem_d [DEPTH];
   logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_ADDR_W:0]   count_q, count_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [0:0]             state_q, state_d;
   logic [1:0]             data_out_q, data_out_d;
   logic                   ctrl_out_q, ctrl_out_d;
   logic                   underrun_q, underrun_d;
   logic                   overflow_q, overflow_d;

   logic       tick;
   logic       push;
   logic       pop;
   logic [2:0] head;

   always_comb begin
      tick       = bit_cnt_q >= (fullSpeedRate ? FS_LAST : LS_LAST);
      USBWireRdy = count_q < DEPTH_C;
      // Room is judged on the registered count, so a same-cycle pop never frees a slot.
      push       = USBWireWEn && USBWireRdy;
      pop        = tick && (count_q != '0);
      head       = mem_q[rd_ptr_q];

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      bit_cnt_d  = tick ? '0 : bit_cnt_q + CNT_W'(1);
      state_d    = state_q;
      data_out_d = data_out_q;
      ctrl_out_d = ctrl_out_q;
      underrun_d = underrun_q | (tick && (count_q == '0) && (state_q == WIRE_ACTIVE));
      overflow_d = overflow_q | (USBWireWEn && !USBWireRdy);

      if (push) begin
         mem_d[wr_ptr_q] = {TxCtl, TxBits};
         wr_ptr_d        = wr_ptr_q + FIFO_ADDR_W'(1);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + FIFO_ADDR_W'(1);
         ctrl_out_d = head[2];
         data_out_d = head[1:0];
         state_d    = head[2] ? WIRE_ACTIVE : WIRE_IDLE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (FIFO_ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         bit_cnt_q  <= '0;
         state_q    <= WIRE_IDLE;
         data_out_q <= 2'b00;
         ctrl_out_q <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         bit_cnt_q  <= bit_cnt_d;
         state_q    <= state_d;
         data_out_q <= data_out_d;
         ctrl_out_q <= ctrl_out_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: count/pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign USBWireDataOut = data_out_q;
   assign USBWireCtrlOut = ctrl_out_q;
   assign txActive       = (state_q == WIRE_ACTIVE);
   assign txUnderrun     = underrun_q;
   assign txOverflow     = overflow_q;

endmodule

// File: tb/tb_usb_tx_wire_driver.sv
// tb/tb_usb_tx_wire_driver.sv - directed vector bench for usb_tx_wire_driver
// Edge numbering: E0 is the reset edge, E1 the first edge with rst low.
module tb_usb_tx_wire_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] TxBits = 2'b00;
   logic       TxCtl = 1'b0;
   logic       USBWireWEn = 1'b0;
   logic       USBWireRdy;
   logic       fullSpeedRate = 1'b0;
   logic [1:0] USBWireDataOut;
   logic       USBWireCtrlOut;
   logic       txActive;
   logic       txUnderrun;
   logic       txOverflow;

   int n_cmp = 0;
   int n_bad = 0;

   usb_tx_wire_driver dut (
      .clk            (clk),
      .rst            (rst),
      .TxBits         (TxBits),
      .TxCtl          (TxCtl),
      .USBWireWEn     (USBWireWEn),
      .USBWireRdy     (USBWireRdy),
      .fullSpeedRate  (fullSpeedRate),
      .USBWireDataOut (USBWireDataOut),
      .USBWireCtrlOut (USBWireCtrlOut),
      .txActive       (txActive),
      .txUnderrun     (txUnderrun),
      .txOverflow     (txOverflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wen;
      logic       ctl;
      logic [1:0] bits;
      logic       rdy;
      logic [1:0] data;
      logic       ctrl;
      logic       act;
      logic       und;
      logic       ovf;
   } vec_t;

   vec_t tbl [1:28];

   function automatic vec_t mk(input logic wen, input logic ctl, input logic [1:0] bits,
                               input logic rdy, input logic [1:0] data, input logic ctrl,
                               input logic act, input logic und, input logic ovf);
      vec_t v;
      v.wen = wen; v.ctl = ctl; v.bits = bits;
      v.rdy = rdy; v.data = data; v.ctrl = ctrl; v.act = act; v.und = und; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic rdy, input logic [1:0] data,
                          input logic ctrl, input logic act, input logic und, input logic ovf);
      chk({tag, " rdy"},  {1'b0, USBWireRdy},     {1'b0, rdy});
      chk({tag, " data"}, USBWireDataOut,         data);
      chk({tag, " ctrl"}, {1'b0, USBWireCtrlOut}, {1'b0, ctrl});
      chk({tag, " act"},  {1'b0, txActive},       {1'b0, act});
      chk({tag, " und"},  {1'b0, txUnderrun},     {1'b0, und});
      chk({tag, " ovf"},  {1'b0, txOverflow},     {1'b0, ovf});
   endtask

   task automatic step(input logic r, input logic w, input logic c, input logic [1:0] b,
                       input logic f);
      @(negedge clk);
      rst = r; USBWireWEn = w; TxCtl = c; TxBits = b; fullSpeedRate = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic f);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, f);
   endtask

   initial begin
      // Full speed from reset: ticks at E4, E8, E12, ...
      for (int i = 1; i <= 4; i++)   tbl[i] = mk(0, 0, 2'b00, 1, 2'b00, 0, 0, 0, 0);
      tbl[5]  = mk(1, 1, 2'b10, 1, 2'b00, 0, 0, 0, 0);
      tbl[6]  = mk(1, 1, 2'b01, 1, 2'b00, 0, 0, 0, 0);
      tbl[7]  = mk(1, 0, 2'b00, 1, 2'b00, 0, 0, 0, 0);
      tbl[8]  = mk(1, 1, 2'b11, 1, 2'b10, 1, 1, 0, 0);
      tbl[9]  = mk(1, 1, 2'b11, 0, 2'b10, 1, 1, 0, 0);
      tbl[10] = mk(1, 1, 2'b00, 0, 2'b10, 1, 1, 0, 1);
      tbl[11] = mk(0, 0, 2'b00, 0, 2'b10, 1, 1, 0, 1);
      for (int i = 12; i <= 15; i++) tbl[i] = mk(0, 0, 2'b00, 1, 2'b01, 1, 1, 0, 1);
      for (int i = 16; i <= 19; i++) tbl[i] = mk(0, 0, 2'b00, 1, 2'b00, 0, 0, 0, 1);
      for (int i = 20; i <= 27; i++) tbl[i] = mk(0, 0, 2'b00, 1, 2'b11, 1, 1, 0, 1);
      tbl[28] = mk(0, 0, 2'b00, 1, 2'b11, 1, 1, 1, 1);

      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      chk_all("reset", 1, 2'b00, 0, 0, 0, 0);
      for (int i = 1; i <= 28; i++) begin
         step(1'b0, tbl[i].wen, tbl[i].ctl, tbl[i].bits, 1'b1);
         chk_all($sformatf("vec E%0d", i), tbl[i].rdy, tbl[i].data, tbl[i].ctrl,
                 tbl[i].act, tbl[i].und, tbl[i].ovf);
      end

      // Low speed latency and underrun: ticks at E32, E64, E96.
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      chk_all("ls reset", 1, 2'b00, 0, 0, 0, 0);
      idle(32, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
      idle(30, 1'b0);
      chk("ls E63 data", USBWireDataOut, 2'b00);
      idle(1, 1'b0);
      chk("ls E64 data", USBWireDataOut, 2'b01);
      chk("ls E64 ctrl", {1'b0, USBWireCtrlOut}, 2'b01);
      chk("ls E64 act", {1'b0, txActive}, 2'b01);
      idle(31, 1'b0);
      chk("ls E95 und", {1'b0, txUnderrun}, 2'b00);
      idle(1, 1'b0);
      chk("ls E96 und", {1'b0, txUnderrun}, 2'b01);
      chk("ls E96 data", USBWireDataOut, 2'b01);

      // Full FIFO with a write held on the popping tick (E32).
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      chk_all("full reset", 1, 2'b00, 0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
      chk_all("full E4", 0, 2'b00, 0, 0, 0, 0);
      idle(27, 1'b0);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      chk_all("full E32", 1, 2'b01, 1, 1, 0, 1);
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
      chk("full E33 rdy", {1'b0, USBWireRdy}, 2'b00);
      idle(2, 1'b1);
      begin
         logic [1:0] exp_drain [4];
         exp_drain[0] = 2'b10; exp_drain[1] = 2'b11; exp_drain[2] = 2'b01; exp_drain[3] = 2'b10;
         for (int k = 0; k < 4; k++) begin
            idle(1, 1'b1);
            chk($sformatf("drain %0d data", k), USBWireDataOut, exp_drain[k]);
            chk($sformatf("drain %0d ctrl", k), {1'b0, USBWireCtrlOut}, 2'b01);
            if (k != 3) idle(3, 1'b1);
         end
      end

      // Reset with three entries queued while driving (E49..E52).
      step(1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
      step(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
      step(1'b0, 1'b1, 1'b0, 2'b10, 1'b1);
      chk("pre-rst ctrl", {1'b0, USBWireCtrlOut}, 2'b01);
      chk("pre-rst ovf", {1'b0, txOverflow}, 2'b01);
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      chk_all("mid rst", 1, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         idle(1, 1'b1);
         chk($sformatf("post-rst %0d data", i), USBWireDataOut, 2'b00);
         chk($sformatf("post-rst %0d ctrl", i), {1'b0, USBWireCtrlOut}, 2'b00);
      end
      chk("post-rst und", {1'b0, txUnderrun}, 2'b00);

      // Rate switch LS->FS with bitCnt=10 ticks at once (E11), then E15, E19.
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
      idle(9, 1'b0);
      chk("rate E10 data", USBWireDataOut, 2'b00);
      idle(1, 1'b1);
      chk("rate E11 data", USBWireDataOut, 2'b01);
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
      step(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
      idle(1, 1'b1);
      chk("rate E14 data", USBWireDataOut, 2'b01);
      idle(1, 1'b1);
      chk("rate E15 data", USBWireDataOut, 2'b10);
      idle(3, 1'b1);
      chk("rate E18 data", USBWireDataOut, 2'b10);
      idle(1, 1'b1);
      chk("rate E19 data", USBWireDataOut, 2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
